uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter; the counterpart of the receive path. Clocked by bclkx8 (8x baud), so one bit time is 8 cycles.
//  Double-buffered: a CPU-side holding register (TDR) feeds a shift register (TSR).
//  Serialises frames LSB-first: start, DATA_BITS data, optional parity, STOP_BITS stop.
//  Back-to-back frames run with no idle gap when TDR is refilled before the stop bits end.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9
//  PARITY_EN   0   1 = append parity bit after data
//  PARITY_ODD  0   parity sense when PARITY_EN=1: 0 = even, 1 = odd
//  STOP_BITS   1   stop bits, legal 1 or 2
// PORTS
//  bclkx8   in   1          8x baud clock, all logic on rising edge
//  rst_n    in   1          reset: asynchronous assert, active-low
//  wr_en    in   1          CPU write strobe for TDR, one cycle per write
//  din      in   DATA_BITS  data written to TDR when wr_en=1
//  txd      out  1          serial line output, registered, idles high
//  tdre     out  1          1 = TDR empty and a write is accepted
//  tx_busy  out  1          1 = FSM not in IDLE (frame in progress)
//  ovr      out  1          one-cycle pulse when a write arrives with tdre=0; that write is dropped
// BEHAVIOUR
//  Reset values (async, immediate): txd=1, tdre=1, tx_busy=0, ovr=0, state=IDLE, ct1=0, ct2=0, TDR=0, TSR=0.
//   Reset during a frame aborts it; txd goes high at once and pending TDR data is discarded.
//  Write rules
//   - wr_en & tdre: TDR<=din and tdre<=0 on that edge.
//   - wr_en & !tdre: TDR is unchanged and ovr=1 for the next cycle.
//  Counters
//   - ct1 (3-bit) counts cycles within a bit, 0..7, and wraps naturally.
//   - ct2 (4-bit) counts bits within the DATA phase, then stop bits in STOP.
//   - Both are cleared on every state entry.
//  FSM states: IDLE, START, DATA, PARITY, STOP (binary-encoded).
//   IDLE:   txd=1. If tdre=0: TSR<=TDR, tdre<=1, go to START.
//   START:  txd=0 for 8 cycles. At ct1==7 go to DATA.
//   DATA:   txd=TSR[0]. At ct1==7, shift TSR right and ct2++.
//           At ct1==7 && ct2==DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
//   PARITY: txd = ^data ^ PARITY_ODD for 8 cycles. Parity is computed at TSR load and held.
//   STOP:   txd=1 for 8*STOP_BITS cycles. At the final ct1==7:
//           - if tdre=0: TSR<=TDR, tdre<=1, go directly to START;
//           - else go to IDLE.
//  Latency and timing
//   - txd is a registered function of state and TSR.
//   - Write accepted at edge N: IDLE load at edge N+1, txd falls at edge N+2.
//   - Frame length = 8*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles; 80 cycles for the 8N1 default.
//  tdre returns to 1 on the TSR-load edge, so the next write may land during the current frame.
//  A write and a TSR load cannot coincide: a load needs tdre=0, and an accepted write needs tdre=1.
//  tx_busy = (state != IDLE), registered with the state.
// STRUCTURE
//  Shared package uart_pkg:
//   - state encodings IDLE..STOP
//   - OVERSAMPLE=8 and the ct1/ct2 widths
//   - default DATA_BITS, shared with the receive path
//  Sub-module sm_tx: FSM only; its next-state logic is combinational.
//   - inputs: tdre, ct1, ct2
//   - outputs: load_TSR, shftTSR, clr1, clr2, inc1, inc2, tx_state
//  uart_tx holds TDR, TSR, the parity flop, both counters, and the txd/tdre/ovr registers.
// TESTING
//  1 Reset, no writes for 100 cycles -> txd=1, tdre=1, tx_busy=0 throughout.
//  2 8N1, write 8'hA5 -> txd low at N+2 for 8 cycles; then bits 1,0,1,0,0,1,0,1 at 8 cycles each; then high; tx_busy 80 cycles.
//  3 PARITY_EN=1, PARITY_ODD=0, write 8'h07 -> parity bit=1; PARITY_ODD=1 -> parity bit=0; frame 88 cycles.
//  4 Write 8'h55, then 8'h3C at cycle 20 -> second start bit begins on the cycle after the first stop bit ends; no idle gap.
//  5 Three writes while tdre=0 -> each extra write pulses ovr for 1 cycle; the TDR value is unchanged.
//  6 Assert rst_n=0 mid-DATA at cycle 37 -> txd=1 immediately, tdre=1; a write after release sends a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART types and constants shared by the transmit and receive paths
package uart_pkg;

   localparam int OVERSAMPLE    = 8;
   localparam int CT1_W         = 3;
   localparam int CT2_W         = 4;
   localparam int DEF_DATA_BITS = 8;

   localparam logic [CT1_W-1:0] CT1_LAST = CT1_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   function automatic logic [CT2_W-1:0] ct2_last(input int count);
      return CT2_W'(count - 1);
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - CPU write port and serial line of the UART transmitter
interface uart_tx_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS
) ();

   logic                 wr_en;
   logic [DATA_BITS-1:0] din;
   logic                 txd;
   logic                 tdre;
   logic                 tx_busy;
   logic                 ovr;

   modport master (output wr_en, din, input txd, tdre, tx_busy, ovr);
   modport slave  (input wr_en, din, output txd, tdre, tx_busy, ovr);

endinterface

// File: rtl/uart_tx_sm_tx.sv
// rtl/uart_tx_sm_tx.sv - transmit frame sequencer: state register plus combinational control
module sm_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int PARITY_EN = 0,
   parameter int STOP_BITS = 1
) (
   input  logic             bclkx8,
   input  logic             rst_n,
   input  logic             tdre,
   input  logic [CT1_W-1:0] ct1,
   input  logic [CT2_W-1:0] ct2,
   output logic             load_TSR,
   output logic             shftTSR,
   output logic             clr1,
   output logic             clr2,
   output logic             inc1,
   output logic             inc2,
   output tx_state_t        tx_state
);

   localparam logic [CT2_W-1:0] DATA_LAST = ct2_last(DATA_BITS);
   localparam logic [CT2_W-1:0] STOP_LAST = ct2_last(STOP_BITS);

   tx_state_t state;
   tx_state_t state_next;
   logic      bit_end;

   assign bit_end  = (ct1 == CT1_LAST);
   assign tx_state = state;

   always_ff @(posedge bclkx8 or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load_TSR   = 1'b0;
      shftTSR    = 1'b0;
      inc1       = 1'b0;
      inc2       = 1'b0;
      case (state)
         IDLE: begin
            if (!tdre) begin
               load_TSR   = 1'b1;
               state_next = START;
            end
         end
         START: begin
            inc1 = 1'b1;
            if (bit_end) begin
               state_next = DATA;
            end
         end
         DATA: begin
            inc1 = 1'b1;
            if (bit_end) begin
               shftTSR = 1'b1;
               inc2    = 1'b1;
               if (ct2 == DATA_LAST) begin
                  state_next = (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            inc1 = 1'b1;
            if (bit_end) begin
               state_next = STOP;
            end
         end
         STOP: begin
            inc1 = 1'b1;
            if (bit_end) begin
               inc2 = 1'b1;
               // A waiting byte skips IDLE so frames run back to back
               if (ct2 == STOP_LAST) begin
                  if (!tdre) begin
                     load_TSR   = 1'b1;
                     state_next = START;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      clr1 = (state_next != state);
      clr2 = (state_next != state);
   end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - double-buffered UART transmitter clocked at 8x baud
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic      bclkx8,
   input  logic      rst_n,
   uart_tx_if.slave  bus
);

   logic [DATA_BITS-1:0] tdr;
   logic [DATA_BITS-1:0] tsr;
   logic                 parity;
   logic                 tdre;
   logic                 txd;
   logic                 ovr;
   logic [CT1_W-1:0]     ct1;
   logic [CT2_W-1:0]     ct2;
   logic                 wr_ok;
   logic                 load_TSR;
   logic                 shftTSR;
   logic                 clr1;
   logic                 clr2;
   logic                 inc1;
   logic                 inc2;
   tx_state_t            tx_state;

   assign wr_ok = bus.wr_en & tdre;

   sm_tx #(
      .DATA_BITS (DATA_BITS),
      .PARITY_EN (PARITY_EN),
      .STOP_BITS (STOP_BITS)
   ) u_sm_tx (
      .bclkx8   (bclkx8),
      .rst_n    (rst_n),
      .tdre     (tdre),
      .ct1      (ct1),
      .ct2      (ct2),
      .load_TSR (load_TSR),
      .shftTSR  (shftTSR),
      .clr1     (clr1),
      .clr2     (clr2),
      .inc1     (inc1),
      .inc2     (inc2),
      .tx_state (tx_state)
   );

   // Writes and TSR loads never share an edge, so tdre has a single owner per cycle
   always_ff @(posedge bclkx8 or negedge rst_n) begin
      if (!rst_n) begin
         tdr  <= '0;
         tdre <= 1'b1;
         ovr  <= 1'b0;
      end else begin
         ovr <= bus.wr_en & ~tdre;
         if (wr_ok) begin
            tdr  <= bus.din;
            tdre <= 1'b0;
         end else if (load_TSR) begin
            tdre <= 1'b1;
         end
      end
   end

   always_ff @(posedge bclkx8 or negedge rst_n) begin
      if (!rst_n) begin
         tsr    <= '0;
         parity <= 1'b0;
      end else if (load_TSR) begin
         tsr    <= tdr;
         parity <= (^tdr) ^ 1'(PARITY_ODD);
      end else if (shftTSR) begin
         tsr <= {1'b0, tsr[DATA_BITS-1:1]};
      end
   end

   always_ff @(posedge bclkx8 or negedge rst_n) begin
      if (!rst_n) begin
         ct1 <= '0;
         ct2 <= '0;
      end else begin
         if (clr1) begin
            ct1 <= '0;
         end else if (inc1) begin
            ct1 <= ct1 + 1'b1;
         end
         if (clr2) begin
            ct2 <= '0;
         end else if (inc2) begin
            ct2 <= ct2 + 1'b1;
         end
      end
   end

   always_ff @(posedge bclkx8 or negedge rst_n) begin
      if (!rst_n) begin
         txd <= 1'b1;
      end else begin
         case (tx_state)
            IDLE:    txd <= 1'b1;
            START:   txd <= 1'b0;
            DATA:    txd <= tsr[0];
            PARITY:  txd <= parity;
            STOP:    txd <= 1'b1;
            default: txd <= 1'b1;
         endcase
      end
   end

   assign bus.txd     = txd;
   assign bus.tdre    = tdre;
   assign bus.tx_busy = (tx_state != IDLE);
   assign bus.ovr     = ovr;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx in 8N1, 8E1 and 8O2 configurations
module tb_uart_tx;

   localparam int NK = 3;

   logic       bclkx8 = 1'b0;
   logic       rst_n  = 1'b1;
   logic       wr_en  = 1'b0;
   logic [7:0] din    = '0;
   int         total  = 0;
   int         bad    = 0;

   always #5 bclkx8 = ~bclkx8;

   uart_tx_if #(.DATA_BITS(8)) bus0 ();
   uart_tx_if #(.DATA_BITS(8)) bus1 ();
   uart_tx_if #(.DATA_BITS(8)) bus2 ();

   assign bus0.wr_en = wr_en;
   assign bus0.din   = din;
   assign bus1.wr_en = wr_en;
   assign bus1.din   = din;
   assign bus2.wr_en = wr_en;
   assign bus2.din   = din;

   uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
      .bclkx8 (bclkx8), .rst_n (rst_n), .bus (bus0));
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
      .bclkx8 (bclkx8), .rst_n (rst_n), .bus (bus1));
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
      .bclkx8 (bclkx8), .rst_n (rst_n), .bus (bus2));

   int exp_len[NK] = '{80, 88, 96};

   function automatic int cfg_pe(input int k);
      return (k == 0) ? 0 : 1;
   endfunction

   function automatic int cfg_odd(input int k);
      return (k == 2) ? 1 : 0;
   endfunction

   function automatic int cfg_sb(input int k);
      return (k == 2) ? 2 : 1;
   endfunction

   function automatic int frame_len(input int k);
      return 8 * (1 + 8 + cfg_pe(k) + cfg_sb(k));
   endfunction

   // Bit idx of a frame: start, data LSB first, optional parity, then stop
   function automatic logic frame_bit(input int k, input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (cfg_pe(k) == 1 && idx == 9) return (^d) ^ (cfg_odd(k) != 0);
      return 1'b1;
   endfunction

   function automatic logic [3:0] outs(input int k);
      case (k)
         0:       return {bus0.txd, bus0.tdre, bus0.tx_busy, bus0.ovr};
         1:       return {bus1.txd, bus1.tdre, bus1.tx_busy, bus1.ovr};
         default: return {bus2.txd, bus2.tdre, bus2.tx_busy, bus2.ovr};
      endcase
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, k, $time, act, exp);
      end
   endtask

   // Schedule model: a byte leaves the holding register at max(write+1, end of current frame)
   bit         m_full[NK];
   logic [7:0] m_tdr[NK];
   int         m_wr[NK];
   int         m_end[NK];
   int         m_load[NK];
   logic [7:0] m_cur[NK];
   bit         m_valid[NK];
   bit         m_ovr[NK];
   bit         was_full;
   int         cyc = 0;

   task automatic model_reset();
      for (int k = 0; k < NK; k++) begin
         m_full[k]  = 1'b0;
         m_tdr[k]   = '0;
         m_wr[k]    = 0;
         m_end[k]   = 0;
         m_load[k]  = 0;
         m_cur[k]   = '0;
         m_valid[k] = 1'b0;
         m_ovr[k]   = 1'b0;
      end
   endtask

   function automatic logic [3:0] model_outs(input int k);
      logic t;
      logic b;
      t = 1'b1;
      b = 1'b0;
      if (m_valid[k]) begin
         if (cyc > m_load[k] && cyc <= m_load[k] + frame_len(k))
            t = frame_bit(k, m_cur[k], (cyc - m_load[k] - 1) / 8);
         b = (cyc >= m_load[k] && cyc < m_load[k] + frame_len(k));
      end
      return {t, ~m_full[k], b, m_ovr[k]};
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge bclkx8 or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            cyc++;
            for (int k = 0; k < NK; k++) begin
               was_full = m_full[k];
               if (was_full && cyc > m_wr[k] && cyc >= m_end[k]) begin
                  m_load[k]  = cyc;
                  m_cur[k]   = m_tdr[k];
                  m_end[k]   = cyc + frame_len(k);
                  m_valid[k] = 1'b1;
                  m_full[k]  = 1'b0;
               end
               m_ovr[k] = wr_en && was_full;
               if (wr_en && !was_full) begin
                  m_full[k] = 1'b1;
                  m_tdr[k]  = din;
                  m_wr[k]   = cyc;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge bclkx8);
         for (int k = 0; k < NK; k++)
            chk("model_outs", k, 32'(outs(k)), 32'(model_outs(k)));
      end
   end

   typedef struct {
      logic [7:0] d;
      logic       par_even;
      logic       par_odd;
   } vec_t;

   vec_t vecs[5];
   logic s_txd[NK][128];
   logic s_busy[NK][128];
   int   busy_cnt[NK];
   logic [3:0] o_main;
   logic [7:0] rx;
   int   nb;

   task automatic tick();
      @(posedge bclkx8);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] d);
      wr_en = 1'b1;
      din   = d;
      @(posedge bclkx8);
      #1;
      wr_en = 1'b0;
   endtask

   function automatic logic all_idle();
      logic r;
      r = 1'b1;
      for (int k = 0; k < NK; k++)
         if (outs(k) !== 4'b1100) r = 1'b0;
      return r;
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      while (!all_idle() && n < 400) begin
         tick();
         n++;
      end
      chk("wait_idle", 0, 32'(all_idle()), 32'(1));
   endtask

   // Sample j = 1..n holds the outputs after the j-th edge following the write edge
   task automatic capture(input int n);
      logic [3:0] o;
      for (int k = 0; k < NK; k++) busy_cnt[k] = 0;
      @(negedge bclkx8);
      for (int j = 1; j <= n; j++) begin
         @(negedge bclkx8);
         for (int k = 0; k < NK; k++) begin
            o = outs(k);
            s_txd[k][j]  = o[3];
            s_busy[k][j] = o[1];
            if (o[1]) busy_cnt[k]++;
         end
      end
   endtask

   task automatic recv_frame(input int k, output logic [7:0] d);
      logic [3:0] o;
      int n;
      d = '0;
      n = 0;
      o = outs(k);
      while (o[3] !== 1'b0 && n < 300) begin
         @(negedge bclkx8);
         o = outs(k);
         n++;
      end
      chk("rx_start_seen", k, 32'(o[3]), 32'(0));
      repeat (4) @(negedge bclkx8);
      for (int b = 0; b < 8; b++) begin
         repeat (8) @(negedge bclkx8);
         o = outs(k);
         d[b] = o[3];
      end
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b1};
      vecs[1] = '{8'h07, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 1'b0, 1'b1};
      vecs[3] = '{8'hFF, 1'b0, 1'b1};
      vecs[4] = '{8'h80, 1'b1, 1'b0};

      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NK; k++) chk("reset_outs", k, 32'(outs(k)), 32'(4'b1100));
      repeat (3) tick();
      rst_n = 1'b1;

      for (int j = 0; j < 100; j++) begin
         @(negedge bclkx8);
         for (int k = 0; k < NK; k++) chk("idle_hold", k, 32'(outs(k)), 32'(4'b1100));
      end

      for (int v = 0; v < 5; v++) begin
         wait_idle();
         write_byte(vecs[v].d);
         capture(100);
         for (int k = 0; k < NK; k++) begin
            chk("pre_start", k, 32'(s_txd[k][1]), 32'(1));
            chk("start_fall", k, 32'(s_txd[k][2]), 32'(0));
            chk("start_last", k, 32'(s_txd[k][9]), 32'(0));
            for (int b = 0; b < 8; b++)
               chk("data_bit", k, 32'(s_txd[k][14 + 8 * b]), 32'(vecs[v].d[b]));
            if (k == 0)
               chk("stop_bit", k, 32'(s_txd[k][78]), 32'(1));
            else
               chk("parity_bit", k, 32'(s_txd[k][78]), 32'((k == 1) ? vecs[v].par_even : vecs[v].par_odd));
            chk("busy_len", k, 32'(busy_cnt[k]), 32'(exp_len[k]));
         end
      end

      wait_idle();
      write_byte(8'h55);
      repeat (19) tick();
      write_byte(8'h3C);
      capture(80);
      for (int k = 0; k < NK; k++) begin
         chk("b2b_last_stop", k, 32'(s_txd[k][exp_len[k] - 19]), 32'(1));
         chk("b2b_start", k, 32'(s_txd[k][exp_len[k] - 18]), 32'(0));
         nb = 0;
         for (int j = 1; j <= exp_len[k] - 18; j++)
            if (s_busy[k][j]) nb++;
         chk("b2b_no_gap", k, 32'(nb), 32'(exp_len[k] - 18));
      end

      wait_idle();
      write_byte(8'h11);
      repeat (4) tick();
      write_byte(8'h22);
      repeat (4) tick();
      for (int w = 0; w < 3; w++) begin
         wr_en = 1'b1;
         din   = 8'(8'h33 + w);
         tick();
         for (int k = 0; k < NK; k++) begin
            o_main = outs(k);
            chk("ovr_pulse", k, 32'(o_main[0]), 32'(1));
            chk("tdre_held", k, 32'(o_main[2]), 32'(0));
         end
      end
      wr_en = 1'b0;
      tick();
      for (int k = 0; k < NK; k++) begin
         o_main = outs(k);
         chk("ovr_clear", k, 32'(o_main[0]), 32'(0));
      end
      repeat (63) tick();
      recv_frame(0, rx);
      chk("tdr_kept", 0, 32'(rx), 32'(8'h22));

      wait_idle();
      write_byte(8'hC3);
      repeat (36) tick();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NK; k++) chk("rst_mid_frame", k, 32'(outs(k)), 32'(4'b1100));
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      write_byte(8'h96);
      recv_frame(0, rx);
      chk("post_rst_frame", 0, 32'(rx), 32'(8'h96));

      wait_idle();
      for (int i = 0; i < 4000; i++) begin
         wr_en = ($urandom_range(0, 99) < 4);
         din   = 8'($urandom);
         tick();
      end
      wr_en = 1'b0;
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
